// File: rtl/param_mc_core.sv
// Multi-cycle 16-bit-instruction core: IDLE/FETCH/EXEC/HALT sequencer, 16-entry register file,
// Z/C flags, relative and absolute branches, with retire/debug visibility of every register write.
module param_mc_core #(
    parameter int DATA_W     = 8,
    parameter int PC_W       = 11,
    parameter bit IMM_SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_valid,
    input  logic [15:0]       imem_rdata,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    output logic              retire,
    output logic              dbg_we,
    output logic [3:0]        dbg_waddr,
    output logic [DATA_W-1:0] dbg_wdata,
    output logic              flag_z,
    output logic              flag_c
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              z_q, z_d, c_q, c_d;
    logic [DATA_W-1:0] rf_q [16];

    logic [3:0]        op;
    logic [DATA_W-1:0] ra, rb, imm4, imm8;
    logic [PC_W-1:0]   off8, jmpTarget;
    logic [DATA_W:0]   sum;
    logic              we, flagUpd;
    logic [3:0]        waddr;
    logic [DATA_W-1:0] wdata;

    assign op        = ir_q[15:12];
    assign ra        = rf_q[ir_q[11:8]];
    assign rb        = rf_q[ir_q[7:4]];
    assign imm4      = IMM_SIGNED ? DATA_W'($signed(ir_q[7:4]))  : DATA_W'(ir_q[7:4]);
    assign imm8      = IMM_SIGNED ? DATA_W'($signed(ir_q[11:4])) : DATA_W'(ir_q[11:4]);
    assign off8      = PC_W'($signed(ir_q[11:4]));
    assign jmpTarget = PC_W'(ir_q[11:0]);

    // Operands are read from rf_q while the write lands at the clock edge, so A==D is safe.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        z_d      = z_q;
        c_d      = c_q;
        sum      = '0;
        we       = 1'b0;
        flagUpd  = 1'b0;
        waddr    = '0;
        wdata    = '0;
        imem_req = 1'b0;
        retire   = 1'b0;
        halted   = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                retire  = 1'b1;
                pc_d    = pc_q + PC_W'(1);
                state_d = (op == 4'hF) ? HALT : FETCH;
                case (op)
                    4'h0: begin
                        sum = {1'b0, ra} + {1'b0, rb};
                        we = 1'b1; flagUpd = 1'b1;
                        wdata = sum[DATA_W-1:0]; c_d = sum[DATA_W];
                    end
                    4'h1: begin
                        sum = {1'b0, ra} - {1'b0, rb};
                        we = 1'b1; flagUpd = 1'b1;
                        wdata = sum[DATA_W-1:0]; c_d = sum[DATA_W];
                    end
                    4'h2: begin we = 1'b1; flagUpd = 1'b1; wdata = ra & rb; c_d = 1'b0; end
                    4'h3: begin we = 1'b1; flagUpd = 1'b1; wdata = ra | rb; c_d = 1'b0; end
                    4'h6: begin we = 1'b1; flagUpd = 1'b1; wdata = ra ^ rb; c_d = 1'b0; end
                    4'h4: begin
                        sum = {1'b0, ra} + {1'b0, imm4};
                        we = 1'b1; flagUpd = 1'b1;
                        wdata = sum[DATA_W-1:0]; c_d = sum[DATA_W];
                    end
                    4'h5: begin we = 1'b1; wdata = imm8; end
                    4'h8: begin
                        if (z_q) pc_d = pc_q + PC_W'(1) + off8;
                    end
                    4'h9: pc_d = jmpTarget;
                    default: ;
                endcase
                if (we) waddr = ir_q[3:0];
                if (flagUpd) z_d = (wdata == '0);
            end
            HALT: halted = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            c_q     <= c_d;
            if (we) rf_q[waddr] <= wdata;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign dbg_we    = we;
    assign dbg_waddr = waddr;
    assign dbg_wdata = wdata;
    assign flag_z    = z_q;
    assign flag_c    = c_q;

endmodule

// File: tb/tb_param_mc_core.sv
// Directed bench for param_mc_core: a variable-latency instruction memory drives the default core,
// and a second core (DATA_W=16, zero-extended immediates) runs from an always-valid memory.
module tb_param_mc_core;

    logic        clk, reset, run;
    logic        imemReq, imemValid, halted, retire, dbgWe, flagZ, flagC;
    logic [10:0] imemAddr, pc;
    logic [15:0] imemRdata;
    logic [3:0]  dbgWaddr;
    logic [7:0]  dbgWdata;

    logic        imemReqB, imemValidB, haltedB, retireB, dbgWeB, flagZB, flagCB;
    logic [10:0] imemAddrB, pcB;
    logic [15:0] imemRdataB;
    logic [3:0]  dbgWaddrB;
    logic [15:0] dbgWdataB;

    logic [15:0] imem  [0:2047];
    logic [15:0] imemB [0:15];

    int checkCnt = 0;
    int passCnt  = 0;
    int cycleCnt = 0;
    int latency  = 1000;
    int waitCnt  = 0;
    bit stabErr  = 1'b0;
    logic [10:0] heldAddr;

    param_mc_core u_dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imemReq), .imem_addr(imemAddr), .imem_valid(imemValid), .imem_rdata(imemRdata),
        .pc(pc), .halted(halted), .retire(retire),
        .dbg_we(dbgWe), .dbg_waddr(dbgWaddr), .dbg_wdata(dbgWdata),
        .flag_z(flagZ), .flag_c(flagC)
    );

    param_mc_core #(.DATA_W(16), .PC_W(11), .IMM_SIGNED(1'b0)) u_dutB (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imemReqB), .imem_addr(imemAddrB), .imem_valid(imemValidB), .imem_rdata(imemRdataB),
        .pc(pcB), .halted(haltedB), .retire(retireB),
        .dbg_we(dbgWeB), .dbg_waddr(dbgWaddrB), .dbg_wdata(dbgWdataB),
        .flag_z(flagZB), .flag_c(flagCB)
    );

    assign imemRdataB = imemB[imemAddrB[3:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCnt++;

    // Memory responder: answers after `latency` waiting cycles and notes any address change while waiting.
    initial begin
        imemValid = 1'b0;
        imemRdata = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                imemValid = 1'b0;
                waitCnt   = 0;
            end else if (imemValid) begin
                imemValid = 1'b0;
                waitCnt   = 0;
            end else if (imemReq) begin
                if (waitCnt == 0) heldAddr = imemAddr;
                else if (imemAddr !== heldAddr) stabErr = 1'b1;
                if (waitCnt >= latency) begin
                    imemValid = 1'b1;
                    imemRdata = imem[imemAddr];
                end
                waitCnt++;
            end else begin
                waitCnt = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp)
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            passCnt++;
    endtask

    task automatic applyStimulus(input int lat);
        latency = lat;
        run     = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        run   = 1'b1;
    endtask

    task automatic waitRetire(input bit useB, output int at);
        bit seen = 1'b0;
        at = -1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if ((useB ? retireB : retire) === 1'b1) begin
                seen = 1'b1;
                at   = cycleCnt;
            end
        end
        if (!seen) checkOutput("retireTimeout", 32'd0, 32'd1);
    endtask

    task automatic checkWrite(input string tag, input logic [3:0] addr, input logic [7:0] data);
        checkOutput({tag, ".we"}, 32'(dbgWe), 32'd1);
        checkOutput({tag, ".waddr"}, 32'(dbgWaddr), 32'(addr));
        checkOutput({tag, ".wdata"}, 32'(dbgWdata), 32'(data));
    endtask

    task automatic checkFlagsNext(input string tag, input bit z, input bit c);
        @(negedge clk);
        checkOutput({tag, ".z"}, 32'(flagZ), 32'(z));
        checkOutput({tag, ".c"}, 32'(flagC), 32'(c));
    endtask

    initial begin
        int t0, t1, t2, reqSeen;
        reset = 1'b0;
        run   = 1'b0;
        imemValidB = 1'b1;
        for (int i = 0; i < 2048; i++) imem[i] = 16'h7000;
        for (int i = 0; i < 16; i++) imemB[i] = 16'hF000;
        imemB[0] = 16'h5FF1;
        imemB[1] = 16'h40F2;
        imemB[2] = 16'h41F4;
        imem[0]  = 16'h5051;
        imem[1]  = 16'h5032;
        imem[2]  = 16'h0123;
        imem[3]  = 16'h5FF1;
        imem[4]  = 16'h4111;
        imem[5]  = 16'h1111;
        imem[6]  = 16'h900A;
        imem[10] = 16'h8040;
        imem[15] = 16'h5014;
        imem[16] = 16'h0405;
        imem[17] = 16'h8040;
        imem[18] = 16'h1046;
        imem[19] = 16'h44F7;
        imem[20] = 16'h2648;
        imem[21] = 16'h6669;
        imem[22] = 16'h97FF;

        repeat (3) @(negedge clk);
        checkOutput("rst.pc", 32'(pc), 32'd0);
        checkOutput("rst.req", 32'(imemReq), 32'd0);
        checkOutput("rst.addr", 32'(imemAddr), 32'd0);
        checkOutput("rst.halted", 32'(halted), 32'd0);
        checkOutput("rst.retire", 32'(retire), 32'd0);
        checkOutput("rst.dbgWe", 32'(dbgWe), 32'd0);
        checkOutput("rst.dbgWdata", 32'(dbgWdata), 32'd0);
        checkOutput("rst.flagZ", 32'(flagZ), 32'd0);
        checkOutput("rst.flagC", 32'(flagC), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle.noReq", 32'(imemReq), 32'd0);

        // Zero-extended immediates on the 16-bit core while the default core stalls in FETCH
        run = 1'b1;
        waitRetire(1'b1, t0);
        checkOutput("zext.ldi", 32'(dbgWdataB), 32'h00FF);
        waitRetire(1'b1, t0);
        checkOutput("zext.addi0", 32'(dbgWdataB), 32'h000F);
        waitRetire(1'b1, t0);
        checkOutput("zext.addi1", 32'(dbgWdataB), 32'h010E);
        waitRetire(1'b1, t0);
        checkOutput("zext.haltNoWe", 32'(dbgWeB), 32'd0);
        @(negedge clk);
        checkOutput("zext.halted", 32'(haltedB), 32'd1);

        // Main program, same-cycle memory
        applyStimulus(0);
        waitRetire(1'b0, t0);
        checkWrite("ldi1", 4'd1, 8'h05);
        waitRetire(1'b0, t1);
        checkWrite("ldi2", 4'd2, 8'h03);
        waitRetire(1'b0, t2);
        checkWrite("add", 4'd3, 8'h08);
        checkOutput("lat0.spacing", 32'(t2 - t1), 32'd2);
        checkFlagsNext("add", 1'b0, 1'b0);
        waitRetire(1'b0, t0);
        checkWrite("ldiFF", 4'd1, 8'hFF);
        waitRetire(1'b0, t0);
        checkWrite("addiWrap", 4'd1, 8'h00);
        checkFlagsNext("addiWrap", 1'b1, 1'b1);
        waitRetire(1'b0, t0);
        checkWrite("subSelf", 4'd1, 8'h00);
        checkFlagsNext("subSelf", 1'b1, 1'b0);
        waitRetire(1'b0, t0);
        checkOutput("jmp.noWe", 32'(dbgWe), 32'd0);
        @(negedge clk);
        checkOutput("jmp.addr", 32'(imemAddr), 32'd10);
        waitRetire(1'b0, t0);
        checkOutput("bzTaken.pc", 32'(pc), 32'd10);
        @(negedge clk);
        checkOutput("bzTaken.addr", 32'(imemAddr), 32'd15);
        waitRetire(1'b0, t0);
        checkWrite("ldiR4", 4'd4, 8'h01);
        checkFlagsNext("ldiKeepsFlags", 1'b1, 1'b0);
        waitRetire(1'b0, t0);
        checkWrite("addR5", 4'd5, 8'h01);
        waitRetire(1'b0, t0);
        @(negedge clk);
        checkOutput("bzNotTaken.addr", 32'(imemAddr), 32'd18);
        waitRetire(1'b0, t0);
        checkWrite("subBorrow", 4'd6, 8'hFF);
        checkFlagsNext("subBorrow", 1'b0, 1'b1);
        waitRetire(1'b0, t0);
        checkWrite("addiNeg", 4'd7, 8'h00);
        checkFlagsNext("addiNeg", 1'b1, 1'b1);
        waitRetire(1'b0, t0);
        checkWrite("and", 4'd8, 8'h01);
        checkFlagsNext("and", 1'b0, 1'b0);
        waitRetire(1'b0, t0);
        checkWrite("xor", 4'd9, 8'h00);
        checkFlagsNext("xor", 1'b1, 1'b0);
        waitRetire(1'b0, t0);
        @(negedge clk);
        checkOutput("jmpTop.addr", 32'(imemAddr), 32'h7FF);
        waitRetire(1'b0, t0);
        checkOutput("nopTop.noWe", 32'(dbgWe), 32'd0);
        @(negedge clk);
        checkOutput("pcWrap", 32'(pc), 32'd0);

        // Retire spacing under 1- and 5-cycle memory latency
        applyStimulus(1);
        stabErr = 1'b0;
        waitRetire(1'b0, t0);
        waitRetire(1'b0, t1);
        waitRetire(1'b0, t2);
        checkOutput("lat1.spacing01", 32'(t1 - t0), 32'd3);
        checkOutput("lat1.spacing12", 32'(t2 - t1), 32'd3);
        applyStimulus(5);
        waitRetire(1'b0, t0);
        waitRetire(1'b0, t1);
        waitRetire(1'b0, t2);
        checkOutput("lat5.spacing01", 32'(t1 - t0), 32'd7);
        checkOutput("lat5.spacing12", 32'(t2 - t1), 32'd7);
        checkWrite("lat5.add", 4'd3, 8'h08);
        checkOutput("addrStable", 32'(stabErr), 32'd0);

        // HALT stops fetching
        imem[0] = 16'h5071;
        imem[1] = 16'hF000;
        applyStimulus(0);
        waitRetire(1'b0, t0);
        checkWrite("preHalt", 4'd1, 8'h07);
        waitRetire(1'b0, t0);
        checkOutput("halt.noWe", 32'(dbgWe), 32'd0);
        @(negedge clk);
        checkOutput("halt.halted", 32'(halted), 32'd1);
        reqSeen = 0;
        repeat (10) begin
            @(negedge clk);
            if (imemReq === 1'b1) reqSeen++;
        end
        checkOutput("halt.noReq", 32'(reqSeen), 32'd0);

        // Reset during a stalled fetch, then restart from pc 0 with cleared registers
        applyStimulus(0);
        waitRetire(1'b0, t0);
        checkWrite("preRst", 4'd1, 8'h07);
        latency = 1000;
        repeat (3) @(negedge clk);
        checkOutput("stall.req", 32'(imemReq), 32'd1);
        checkOutput("stall.addr", 32'(imemAddr), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("midRst.req", 32'(imemReq), 32'd0);
        checkOutput("midRst.pc", 32'(pc), 32'd0);
        imem[0] = 16'h0113;
        latency = 1;
        @(negedge clk);
        reset = 1'b1;
        waitRetire(1'b0, t0);
        checkOutput("restart.pc", 32'(pc), 32'd0);
        checkWrite("regsCleared", 4'd3, 8'h00);
        checkFlagsNext("regsCleared", 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
